// File: rtl/vector_control_sequencer.sv
// ---------------------------------------------------------------------------
// vector_control_sequencer
//
// Decodes a 5-bit opcode plus 3-bit ALU function into a 19-bit control word.
// Scalar instructions produce one beat. Vector instructions produce
// VLEN/LANES beats that share one control word, each beat tagged with the
// index of its first element. The control word is registered, so a beat
// appears on the outputs the cycle after the instruction is accepted.
//
// Parameters
//   LANES  elements processed per beat (power of two, 1..16)
//   VLEN   elements per vector register (power of two, multiple of LANES)
//   IDX_W  width of elem_idx_o
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   valid_i        instruction present on OPcode/ALUop
//   OPcode, ALUop  instruction opcode and ALU function field
//   flush_i        drop the running and offered instruction
//   ready_o        instruction taken this cycle when valid_i & ready_o
//   ctrl_valid_o   ctrl_o / elem_idx_o / last_beat_o hold a beat
//   ctrl_o         {JMPSel[1:0], WriteRegister, MemWrite, RegWrite, vcsub,
//                   ALUOp[2:0], SelectorOpB[1:0], SelectorRs2, BranchSel[1:0],
//                   SelectorOpA[1:0], SelWriteData, WriteRegisterVec,
//                   SelectorRs1}
//   elem_idx_o     first element index of the current beat
//   last_beat_o    current beat is the final one of its instruction
//   illegal_o      sticky unknown-opcode flag (trap build only, else 0)
//
// Control table (fields not listed are 0)
//   00000 R-type  WriteRegister RegWrite ALUOp=ALUop SelectorRs2
//   01000 ADDI    WriteRegister RegWrite SelectorOpB=01
//   00010 LW      WriteRegister RegWrite SelectorOpB=01 SelWriteData
//   00011 SW      MemWrite SelectorOpB=01 SelectorRs2
//   00100 BEQ     ALUOp=001 BranchSel=01 SelectorRs2
//   00101 BNE     ALUOp=001 BranchSel=10 SelectorRs2
//   00110 JAL     JMPSel=01 WriteRegister RegWrite SelectorOpA=01
//   00111 JALR    JMPSel=10 WriteRegister RegWrite SelectorOpA=01
//   11000 VALU    RegWrite WriteRegisterVec ALUOp=ALUop vcsub=(ALUop==001)
//                 SelectorOpA=10 SelectorOpB=10 SelectorRs1 SelectorRs2
//   11011 VMUL    RegWrite WriteRegisterVec ALUOp=011
//                 SelectorOpA=10 SelectorOpB=10 SelectorRs1 SelectorRs2
//   11110 VLDH    RegWrite WriteRegisterVec SelWriteData SelectorOpB=01
//                 SelectorRs1
//   11101 VSTB    MemWrite SelectorOpB=01 SelectorRs1 SelectorRs2
//
// Configuration
//   VCS_ILLEGAL_TRAP_EN  defined: an accepted unknown opcode emits no beat
//                        and sets illegal_o until reset or flush.
//                        undefined: an unknown opcode is a one-beat NOP.
// ---------------------------------------------------------------------------
module vector_control_sequencer #(
    parameter int LANES = 4,
    parameter int VLEN  = 16,
    parameter int IDX_W = $clog2(VLEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [4:0]       OPcode,
    input  logic [2:0]       ALUop,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             ctrl_valid_o,
    output logic [18:0]      ctrl_o,
    output logic [IDX_W-1:0] elem_idx_o,
    output logic             last_beat_o,
    output logic             illegal_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        VBUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic [1:0] jmp_sel;
        logic       write_register;
        logic       mem_write;
        logic       reg_write;
        logic       vcsub;
        logic [2:0] alu_op;
        logic [1:0] sel_op_b;
        logic       sel_rs2;
        logic [1:0] branch_sel;
        logic [1:0] sel_op_a;
        logic       sel_write_data;
        logic       write_register_vec;
        logic       sel_rs1;
    } ctrl_t;

    localparam bit               MULTI_BEAT = (VLEN / LANES) > 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(VLEN - LANES);
    localparam logic [IDX_W-1:0] STEP       = IDX_W'(LANES);

    state_e           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d, dec;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             known;
    logic             is_vec;
    logic             trap_hit;

    // ---------------------------------------------------------------------
    // Opcode decode
    // ---------------------------------------------------------------------
    // NOTE: every always_comb output gets a default before the case, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        dec    = '0;
        known  = 1'b1;
        is_vec = 1'b0;
        case (OPcode)
            5'b00000: begin
                dec.write_register = 1'b1;
                dec.reg_write      = 1'b1;
                dec.alu_op         = ALUop;
                dec.sel_rs2        = 1'b1;
            end
            5'b01000: begin
                dec.write_register = 1'b1;
                dec.reg_write      = 1'b1;
                dec.sel_op_b       = 2'b01;
            end
            5'b00010: begin
                dec.write_register = 1'b1;
                dec.reg_write      = 1'b1;
                dec.sel_op_b       = 2'b01;
                dec.sel_write_data = 1'b1;
            end
            5'b00011: begin
                dec.mem_write = 1'b1;
                dec.sel_op_b  = 2'b01;
                dec.sel_rs2   = 1'b1;
            end
            5'b00100: begin
                dec.alu_op     = 3'b001;
                dec.branch_sel = 2'b01;
                dec.sel_rs2    = 1'b1;
            end
            5'b00101: begin
                dec.alu_op     = 3'b001;
                dec.branch_sel = 2'b10;
                dec.sel_rs2    = 1'b1;
            end
            5'b00110: begin
                dec.jmp_sel        = 2'b01;
                dec.write_register = 1'b1;
                dec.reg_write      = 1'b1;
                dec.sel_op_a       = 2'b01;
            end
            5'b00111: begin
                dec.jmp_sel        = 2'b10;
                dec.write_register = 1'b1;
                dec.reg_write      = 1'b1;
                dec.sel_op_a       = 2'b01;
            end
            5'b11000: begin
                is_vec                 = 1'b1;
                dec.reg_write          = 1'b1;
                dec.write_register_vec = 1'b1;
                dec.alu_op             = ALUop;
                dec.vcsub              = (ALUop == 3'b001);
                dec.sel_op_a           = 2'b10;
                dec.sel_op_b           = 2'b10;
                dec.sel_rs1            = 1'b1;
                dec.sel_rs2            = 1'b1;
            end
            5'b11011: begin
                is_vec                 = 1'b1;
                dec.reg_write          = 1'b1;
                dec.write_register_vec = 1'b1;
                dec.alu_op             = 3'b011;
                dec.sel_op_a           = 2'b10;
                dec.sel_op_b           = 2'b10;
                dec.sel_rs1            = 1'b1;
                dec.sel_rs2            = 1'b1;
            end
            5'b11110: begin
                is_vec                 = 1'b1;
                dec.reg_write          = 1'b1;
                dec.write_register_vec = 1'b1;
                dec.sel_write_data     = 1'b1;
                dec.sel_op_b           = 2'b01;
                dec.sel_rs1            = 1'b1;
            end
            5'b11101: begin
                is_vec        = 1'b1;
                dec.mem_write = 1'b1;
                dec.sel_op_b  = 2'b01;
                dec.sel_rs1   = 1'b1;
                dec.sel_rs2   = 1'b1;
            end
            default: known = 1'b0;
        endcase
    end

    // Ready only in IDLE: the last beat of a vector already returns the
    // state to IDLE, which gives back-to-back issue without a bubble.
    assign ready_o = rst_n && (state_q == IDLE) && !flush_i;

    // ---------------------------------------------------------------------
    // Unknown-opcode handling
    // ---------------------------------------------------------------------
`ifdef VCS_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    assign trap_hit  = !known;
    assign illegal_o = illegal_q;

    always_comb begin
        illegal_d = illegal_q;
        if (flush_i) begin
            illegal_d = 1'b0;
        end else if (valid_i && ready_o && trap_hit) begin
            illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end
`else
    assign trap_hit  = 1'b0;
    assign illegal_o = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Beat sequencer
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ctrl_d  = '0;
        valid_d = 1'b0;
        idx_d   = '0;
        last_d  = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i && !trap_hit) begin
                        valid_d = 1'b1;
                        // An unknown opcode is a NOP: all-zero word.
                        ctrl_d  = known ? dec : ctrl_t'('0);
                        if (is_vec && MULTI_BEAT) begin
                            state_d = VBUSY;
                        end else begin
                            last_d = 1'b1;
                        end
                    end
                end
                VBUSY: begin
                    valid_d = 1'b1;
                    ctrl_d  = ctrl_q;
                    idx_d   = idx_q + STEP;
                    if (idx_d == LAST_IDX) begin
                        last_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign ctrl_valid_o = valid_q;
    assign ctrl_o       = ctrl_q;
    assign elem_idx_o   = idx_q;
    assign last_beat_o  = last_q;

endmodule

// File: tb/tb_vector_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vector_control_sequencer
//
// Directed bench for vector_control_sequencer with LANES=4, VLEN=16. A
// queue-based model holds the beats still owed to the outputs; a compare
// process checks the DUT against it on every negative clock edge, and the
// stimulus block adds hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_vector_control_sequencer;

    localparam int LANES = 4;
    localparam int VLEN  = 16;
    localparam int IDX_W = $clog2(VLEN);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_LW   = 5'b00010;
    localparam logic [4:0] OP_SW   = 5'b00011;
    localparam logic [4:0] OP_BEQ  = 5'b00100;
    localparam logic [4:0] OP_BNE  = 5'b00101;
    localparam logic [4:0] OP_JAL  = 5'b00110;
    localparam logic [4:0] OP_JALR = 5'b00111;
    localparam logic [4:0] OP_VADD = 5'b11000;
    localparam logic [4:0] OP_VMUL = 5'b11011;
    localparam logic [4:0] OP_VLDH = 5'b11110;
    localparam logic [4:0] OP_VSTB = 5'b11101;
    localparam logic [4:0] OP_BAD  = 5'b11111;

    localparam logic [18:0] ADDI_WORD = 19'b0010100000100000000;
    localparam logic [18:0] LW_WORD   = 19'b0010100000100000100;

    logic             clk;
    logic             rst_n;
    logic             valid_i;
    logic [4:0]       OPcode;
    logic [2:0]       ALUop;
    logic             flush_i;
    logic             ready_o;
    logic             ctrl_valid_o;
    logic [18:0]      ctrl_o;
    logic [IDX_W-1:0] elem_idx_o;
    logic             last_beat_o;
    logic             illegal_o;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    vector_control_sequencer #(
        .LANES(LANES),
        .VLEN (VLEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_i     (valid_i),
        .OPcode      (OPcode),
        .ALUop       (ALUop),
        .flush_i     (flush_i),
        .ready_o     (ready_o),
        .ctrl_valid_o(ctrl_valid_o),
        .ctrl_o      (ctrl_o),
        .elem_idx_o  (elem_idx_o),
        .last_beat_o (last_beat_o),
        .illegal_o   (illegal_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------
    // Model: ISA table expressed as named fields, plus a beat queue.
    // -----------------------------------------------------------------
    function automatic logic [18:0] model_word(input logic [4:0] op, input logic [2:0] fn,
                                               output bit known, output bit vec);
        logic [1:0] jmp = 2'b00, opb = 2'b00, br = 2'b00, opa = 2'b00;
        logic [2:0] alu = 3'b000;
        logic wr = 0, mw = 0, rw = 0, vs = 0, rs2 = 0, wd = 0, wrv = 0, rs1 = 0;
        known = 1'b1;
        vec   = 1'b0;
        case (op)
            OP_R:    begin wr = 1; rw = 1; alu = fn; rs2 = 1; end
            OP_ADDI: begin wr = 1; rw = 1; opb = 2'b01; end
            OP_LW:   begin wr = 1; rw = 1; opb = 2'b01; wd = 1; end
            OP_SW:   begin mw = 1; opb = 2'b01; rs2 = 1; end
            OP_BEQ:  begin alu = 3'b001; br = 2'b01; rs2 = 1; end
            OP_BNE:  begin alu = 3'b001; br = 2'b10; rs2 = 1; end
            OP_JAL:  begin jmp = 2'b01; wr = 1; rw = 1; opa = 2'b01; end
            OP_JALR: begin jmp = 2'b10; wr = 1; rw = 1; opa = 2'b01; end
            OP_VADD: begin vec = 1; rw = 1; wrv = 1; alu = fn; vs = (fn == 3'b001);
                           opa = 2'b10; opb = 2'b10; rs1 = 1; rs2 = 1; end
            OP_VMUL: begin vec = 1; rw = 1; wrv = 1; alu = 3'b011;
                           opa = 2'b10; opb = 2'b10; rs1 = 1; rs2 = 1; end
            OP_VLDH: begin vec = 1; rw = 1; wrv = 1; wd = 1; opb = 2'b01; rs1 = 1; end
            OP_VSTB: begin vec = 1; mw = 1; opb = 2'b01; rs1 = 1; rs2 = 1; end
            default: known = 1'b0;
        endcase
        return {jmp, wr, mw, rw, vs, alu, opb, rs2, br, opa, wd, wrv, rs1};
    endfunction

    typedef struct {
        logic [18:0] ctrl;
        int          idx;
        bit          last;
    } beat_t;

    beat_t exp_q[$];
    bit    m_illegal = 1'b0;
    bit    m_acc;
    bit    m_known;
    bit    m_vec;
    logic [18:0] m_word;

    // Front of the queue is the beat on the outputs now; the sequencer can
    // take a new instruction once nothing is owed after it.
    function automatic bit m_ready();
        return (exp_q.size() <= 1) && !flush_i;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_illegal = 1'b0;
        end else begin
            m_acc = valid_i && m_ready();
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (flush_i) begin
                exp_q.delete();
                m_illegal = 1'b0;
            end else if (m_acc) begin
                m_word = model_word(OPcode, ALUop, m_known, m_vec);
`ifdef VCS_ILLEGAL_TRAP_EN
                if (!m_known) m_illegal = 1'b1;
                else
`endif
                begin
                    for (int k = 0; k < (m_vec ? VLEN / LANES : 1); k++) begin
                        exp_q.push_back('{ctrl: m_word, idx: k * LANES,
                                          last: (k == (m_vec ? VLEN / LANES : 1) - 1)});
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            if (exp_q.size() > 0) begin
                check("m_valid", ctrl_valid_o, 1);
                check("m_ctrl", ctrl_o, exp_q[0].ctrl);
                check("m_idx", elem_idx_o, exp_q[0].idx);
                check("m_last", last_beat_o, exp_q[0].last);
            end else begin
                check("m_valid", ctrl_valid_o, 0);
                check("m_ctrl", ctrl_o, 0);
                check("m_idx", elem_idx_o, 0);
                check("m_last", last_beat_o, 0);
            end
            check("m_ready", ready_o, m_ready());
            check("m_illegal", illegal_o, m_illegal);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------
    // Stimulus and literal expectations
    // -----------------------------------------------------------------
    logic [4:0] scalar_ops [7] = '{OP_R, OP_SW, OP_BEQ, OP_BNE, OP_JAL, OP_JALR, OP_LW};
    bit got;
    int accept_n;

    initial begin
        rst_n   = 1'b0;
        valid_i = 1'b0;
        OPcode  = '0;
        ALUop   = '0;
        flush_i = 1'b0;
        #2;
        check("rst_valid", ctrl_valid_o, 0);
        check("rst_ctrl", ctrl_o, 0);
        check("rst_idx", elem_idx_o, 0);
        check("rst_last", last_beat_o, 0);
        check("rst_illegal", illegal_o, 0);
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // ADDI: one beat, fixed word
        valid_i = 1'b1; OPcode = OP_ADDI; ALUop = 3'b000;
        next_cycle();
        valid_i = 1'b0;
        @(negedge clk);
        check("addi_valid", ctrl_valid_o, 1);
        check("addi_ctrl", ctrl_o, ADDI_WORD);
        check("addi_last", last_beat_o, 1);
        check("addi_idx", elem_idx_o, 0);
        next_cycle();
        @(negedge clk);
        check("idle_valid", ctrl_valid_o, 0);
        check("idle_ctrl", ctrl_o, 0);

        // VADD: four beats 0,4,8,12, ready low for three of them
        next_cycle();
        valid_i = 1'b1; OPcode = OP_VADD; ALUop = 3'b001;
        next_cycle();
        valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("vadd_idx", elem_idx_o, k * 4);
            check("vadd_last", last_beat_o, k == 3);
            check("vadd_ready", ready_o, k == 3);
            next_cycle();
        end

        // VLDH then LW held valid: LW taken on VLDH's last beat
        valid_i = 1'b1; OPcode = OP_VLDH; ALUop = 3'b000;
        next_cycle();
        OPcode   = OP_LW;
        got      = 1'b0;
        accept_n = -1;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (ready_o) begin
                got      = 1'b1;
                accept_n = n;
                check("b2b_last", last_beat_o, 1);
                check("b2b_idx", elem_idx_o, 12);
            end
            next_cycle();
        end
        valid_i = 1'b0;
        check("b2b_accepted", got, 1);
        check("b2b_wait", accept_n, 3);
        @(negedge clk);
        check("lw_valid", ctrl_valid_o, 1);
        check("lw_ctrl", ctrl_o, LW_WORD);
        check("lw_last", last_beat_o, 1);

        // VMUL flushed on its idx=4 beat
        next_cycle();
        valid_i = 1'b1; OPcode = OP_VMUL;
        next_cycle();
        valid_i = 1'b0;
        @(negedge clk);
        check("vmul_idx0", elem_idx_o, 0);
        next_cycle();
        flush_i = 1'b1;
        @(negedge clk);
        check("vmul_idx4", elem_idx_o, 4);
        check("vmul_ready_busy", ready_o, 0);
        next_cycle();
        flush_i = 1'b0;
        @(negedge clk);
        check("flush_valid", ctrl_valid_o, 0);
        check("flush_ready", ready_o, 1);
        check("flush_idx", elem_idx_o, 0);

        // Instruction offered during flush is refused
        next_cycle();
        valid_i = 1'b1; OPcode = OP_ADDI; flush_i = 1'b1;
        @(negedge clk);
        check("flush_refuse_ready", ready_o, 0);
        next_cycle();
        valid_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        check("flush_refuse_valid", ctrl_valid_o, 0);

        // Unknown opcode
        next_cycle();
        valid_i = 1'b1; OPcode = OP_BAD;
        next_cycle();
        valid_i = 1'b0;
        @(negedge clk);
`ifdef VCS_ILLEGAL_TRAP_EN
        check("bad_illegal", illegal_o, 1);
        check("bad_valid", ctrl_valid_o, 0);
        check("bad_ready", ready_o, 1);
        next_cycle();
        @(negedge clk);
        check("bad_sticky", illegal_o, 1);
        next_cycle();
        flush_i = 1'b1;
        next_cycle();
        flush_i = 1'b0;
        @(negedge clk);
        check("bad_cleared", illegal_o, 0);
`else
        check("nop_valid", ctrl_valid_o, 1);
        check("nop_ctrl", ctrl_o, 0);
        check("nop_last", last_beat_o, 1);
        check("nop_illegal", illegal_o, 0);
`endif

        // Back-to-back scalar instructions, checked by the model
        next_cycle();
        valid_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            OPcode = scalar_ops[i];
            ALUop  = 3'(i);
            next_cycle();
        end
        valid_i = 1'b0;
        next_cycle();

        // Reset dropped mid-VSTB
        valid_i = 1'b1; OPcode = OP_VSTB; ALUop = 3'b000;
        next_cycle();
        valid_i = 1'b0;
        next_cycle();
        check("vstb_idx4", elem_idx_o, 4);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_valid", ctrl_valid_o, 0);
        check("async_ctrl", ctrl_o, 0);
        check("async_idx", elem_idx_o, 0);
        check("async_last", last_beat_o, 0);
        check("async_illegal", illegal_o, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", ready_o, 1);
        check("post_rst_valid", ctrl_valid_o, 0);

        // One more instruction after reset
        next_cycle();
        valid_i = 1'b1; OPcode = OP_VADD; ALUop = 3'b010;
        next_cycle();
        valid_i = 1'b0;
        repeat (6) next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vector_control_sequencer.md
VECTOR_CONTROL_SEQUENCER -- requirements
Module: vector_control_sequencer

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning vector elements processed per beat (power of two, 1..16).
REQ-002 SHALL have parameter VLEN, default 16, meaning elements per vector register (power of two, multiple of LANES).
REQ-003 SHALL have parameter IDX_W, default $clog2(VLEN), meaning width of the element-index output.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port valid_i  input  1  instruction present on OPcode/ALUop.
REQ-007 SHALL have port OPcode  input  5  instruction opcode.
REQ-008 SHALL have port ALUop  input  3  ALU function field.
REQ-009 SHALL have port flush_i  input  1  discard current and pending work.
REQ-010 SHALL have port ready_o  output  1  instruction accepted this cycle when valid_i&ready_o.
REQ-011 SHALL have port ctrl_valid_o  output  1  ctrl_o/elem_idx_o valid this cycle.
REQ-012 SHALL have port ctrl_o  output  19  control word {JMPSel[1:0], WriteRegister, MemWrite, RegWrite, vcsub, ALUOp[2:0], SelectorOpB[1:0], SelectorRs2, BranchSel[1:0], SelectorOpA[1:0], SelWriteData, WriteRegisterVec, SelectorRs1}.
REQ-013 SHALL have port elem_idx_o  output  IDX_W  first element index of current beat.
REQ-014 SHALL have port last_beat_o  output  1  final beat of current instruction.
REQ-015 SHALL have port illegal_o  output  1  unrecognised opcode flag (see Configuration).

Function
REQ-016 SHALL decode OPcode/ALUop into ctrl_o per ISA control table v1; every don't-care bit SHALL be driven 0, never X.
REQ-017 SHALL register the decoded word: ctrl_o valid exactly 1 cycle after acceptance (latency 1).
REQ-018 SHALL implement states IDLE and VBUSY.
REQ-019 IDLE: ready_o=1; accepted scalar opcode -> one beat, ctrl_valid_o=1, last_beat_o=1, elem_idx_o=0, stay IDLE.
REQ-020 IDLE: accepted vector opcode (11000, 11110, 11011, 11101) -> first beat next cycle, elem_idx_o=0; go VBUSY if VLEN/LANES>1.
REQ-021 VBUSY: ready_o=0; each cycle emit one beat with same ctrl_o, elem_idx_o incremented by LANES.
REQ-022 Beat with elem_idx_o=VLEN-LANES SHALL assert last_beat_o and return to IDLE; ready_o=1 in that same cycle (back-to-back issue, no bubble).
REQ-023 VLEN==LANES: vector ops SHALL be single-beat, never enter VBUSY.
REQ-024 elem_idx_o SHALL never wrap past VLEN-LANES; counter resets to 0 at each new instruction.
REQ-025 valid_i=0 in IDLE -> ctrl_valid_o=0 next cycle, ctrl_o=0.
REQ-026 flush_i=1 SHALL take priority over all: next cycle IDLE, ctrl_valid_o=0, counter 0; the instruction offered during flush is not accepted (ready_o=0 while flush_i=1).
REQ-027 Inputs while ready_o=0 SHALL be ignored; upstream holds them.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, ctrl_o=0, ctrl_valid_o=0, elem_idx_o=0, last_beat_o=0, illegal_o=0, internal counter 0.
REQ-029 Reset asserted mid-VBUSY SHALL abandon the instruction; first cycle after deassertion ready_o=1.

Configuration
REQ-030 Macro VCS_ILLEGAL_TRAP_EN SHALL control illegal-opcode handling.
REQ-031 With VCS_ILLEGAL_TRAP_EN defined: accepted unknown opcode -> ctrl_valid_o=0, illegal_o=1 sticky until reset or flush_i; ready_o stays 1.
REQ-032 Without it: unknown opcode treated as NOP (one beat, ctrl_o=0, ctrl_valid_o=1); illegal_o tied 0.

Verification
REQ-033 Reset then ADDI (01000) valid one cycle -> next cycle ctrl_valid_o=1, ctrl_o=19'b0010100000100000000, last_beat_o=1.
REQ-034 LANES=4, VLEN=16, VADD (11000, ALUop=001) -> 4 beats, elem_idx_o 0,4,8,12, last_beat_o only on 12, ready_o low 3 cycles.
REQ-035 VLDH then LW back-to-back held valid -> LW accepted on VLDH's last-beat cycle; LW ctrl_o next cycle, no bubble.
REQ-036 flush_i pulsed during beat elem_idx_o=4 of VMUL -> next cycle ctrl_valid_o=0, ready_o=1, elem_idx_o=0.
REQ-037 OPcode 5'b11111 with VCS_ILLEGAL_TRAP_EN -> illegal_o=1 held until flush; without macro -> ctrl_o=0, ctrl_valid_o=1.
REQ-038 rst_n dropped asynchronously mid-VSTB -> outputs 0 before next clock edge; after release ready_o=1.
